cordic_ctrl: RTL

Iterative CORDIC rotation-mode engine and sequencer for the arctangent angle ROM (`rom`, 16 entries, Q8.24 degrees). On a start handshake it latches a target angle and steps the ROM address through iterations 0..ITER-1, one per clock. Each cycle it performs the shift-add micro-rotation and then presents cos/sin of the angle with a one-cycle done pulse. It sits between the user-facing angle source and the ROM, and is the only driver of the ROM address.

---
 rtl/cordic_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/cordic_ctrl.sv
// cordic_ctrl: iterative rotation-mode CORDIC engine that sequences the arctangent ROM
module cordic_ctrl #(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int ITER = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] angle_i,
  output logic [M-1:0] rom_addr_o,
  input  logic [N-1:0] rom_angle_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [N-1:0] cos_o,
  output logic [N-1:0] sin_o
);
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  localparam logic signed [N-1:0] LIM = N'(32'sh5A000000);
  localparam logic signed [N-1:0] K   = N'(32'sh26DD3B6A);
  state_t              r_state, w_next;
  logic [M-1:0]        r_cnt;
  logic signed [N-1:0] r_x, r_y, r_z;
  logic signed [N-1:0] w_x_nx, w_y_nx, w_z_nx, w_xs, w_ys;
  logic [N-1:0]        r_cos, r_sin;
  logic                r_busy, r_done, r_err;
  logic                w_ok, w_last, w_neg, w_acc;
  assign w_ok   = ($signed(angle_i) <= LIM) && ($signed(angle_i) >= -LIM);
  assign w_acc  = r_state == S_IDLE && start_i && w_ok;
  assign w_last = r_cnt == M'(ITER - 1);
  assign w_neg  = r_z[N-1];
  assign w_xs   = r_x >>> r_cnt;
  assign w_ys   = r_y >>> r_cnt;
  assign w_x_nx = w_neg ? r_x + w_ys : r_x - w_ys;
  assign w_y_nx = w_neg ? r_y - w_xs : r_y + w_xs;
  assign w_z_nx = w_neg ? r_z + $signed(rom_angle_i) : r_z - $signed(rom_angle_i);
  assign rom_addr_o = r_state == S_ITER ? r_cnt : '0;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign err_o  = r_err;
  assign cos_o  = r_cos;
  assign sin_o  = r_sin;
  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end
  // next-state decode: accept in IDLE, iterate ITER times, one DONE cycle
  always_comb begin
    w_next = r_state;
    if (w_acc)                             w_next = S_ITER;
    else if (r_state == S_ITER && w_last)  w_next = S_DONE;
    else if (r_state == S_DONE)            w_next = S_IDLE;
  end
  // datapath: load on accept, micro-rotate in ITER, capture results on the last step
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_cnt  <= '0;
      r_cos  <= '0;
      r_sin  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_next != S_IDLE;
      r_done <= w_next == S_DONE;
      r_err  <= r_state == S_IDLE && start_i && !w_ok;
      if (w_acc) begin
        r_x   <= K;
        r_y   <= '0;
        r_z   <= $signed(angle_i);
        r_cnt <= '0;
      end else if (r_state == S_ITER) begin
        r_x   <= w_x_nx;
        r_y   <= w_y_nx;
        r_z   <= w_z_nx;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_cos <= w_x_nx;
          r_sin <= w_y_nx;
        end
      end
    end
  end
endmodule
